// File: rtl/complex_accumulator_array_pkg.sv
// complex_accumulator_array shared types and fp32 helpers.
// fp32_add is round-to-nearest-even with IEEE NaN/Inf propagation.
package complex_accumulator_array_pkg;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  typedef complex_t [0:3][0:3] tile_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ADD,
    S_DONE
  } state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

  function automatic logic fp32_is_naninf(
    input logic [31:0] x
  );
    return &x[30:23];
  endfunction

  function automatic logic [31:0] fp32_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, sh;
    logic [27:0] s;
    logic [24:0] m;
    logic        st, up;
    int          e;
    if ((&a[30:23] && |a[22:0]) ||
        (&b[30:23] && |b[22:0]))
      return 32'h7FC0_0000;
    if (&a[30:23])
      return (&b[30:23] && a[31] != b[31]) ?
        32'h7FC0_0000 : a;
    if (&b[30:23])
      return b;
    x = a;
    y = b;
    if (b[30:0] > a[30:0]) begin
      x = b;
      y = a;
    end
    // subnormals share the exponent of 1
    ex = x[30:23] | {7'd0, ~|x[30:23]};
    ey = y[30:23] | {7'd0, ~|y[30:23]};
    mx = {|x[30:23], x[22:0], 3'b000};
    my = {|y[30:23], y[22:0], 3'b000};
    d  = ex - ey;
    if (d > 8'd26) begin
      sh = '0;
      st = |my;
    end else begin
      sh = my >> d;
      st = |(my & ~(27'h7FF_FFFF << d));
    end
    sh[0] = sh[0] | st;
    if (x[31] == y[31])
      s = {1'b0, mx} + {1'b0, sh};
    else
      s = {1'b0, mx} - {1'b0, sh};
    if (s == '0)
      return {x[31] & y[31], 31'd0};
    e = int'(ex);
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e++;
    end
    for (int k = 0; k < 26; k++) begin
      if (!s[26] && e > 1) begin
        s = s << 1;
        e--;
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = {1'b0, s[26:3]} + 25'(up);
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255)
      return {x[31], 8'hFF, 23'd0};
    return {x[31], m[23] ? 8'(e) : 8'h00, m[22:0]};
  endfunction

endpackage

// File: rtl/complex_accumulator_array_if.sv
// Tile-in / tile-out valid-ready bundle.
// nan_flag exists only with COMPLEX_ACC_NAN_FLAG_EN.
interface complex_accumulator_array_if;
  import complex_accumulator_array_pkg::*;

  tile_t in;
  logic  in_valid;
  logic  in_ready;
  tile_t out;
  logic  out_valid;
  logic  out_ready;
`ifdef COMPLEX_ACC_NAN_FLAG_EN
  logic  nan_flag;
`endif

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid
`ifdef COMPLEX_ACC_NAN_FLAG_EN
    , input nan_flag
`endif
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid
`ifdef COMPLEX_ACC_NAN_FLAG_EN
    , output nan_flag
`endif
  );

endinterface

// File: rtl/complex_accumulator_array_lane.sv
// One tile element: accumulator plus re/im adders of latency ADD_LAT.
// naninf port exists only with COMPLEX_ACC_NAN_FLAG_EN.
module complex_accumulator_array_lane
  import complex_accumulator_array_pkg::*;
#(
  parameter int ADD_LAT = 7
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     commit,
  input  complex_t din,
  output complex_t acc
`ifdef COMPLEX_ACC_NAN_FLAG_EN
  , output logic   naninf
`endif
);

  complex_t pipe [1:ADD_LAT];

  // adder pipeline; the top only commits the slot it launched
  always_ff @(posedge clk) begin
    pipe[1] <= '{re: fp32_add(acc.re, din.re),
                 im: fp32_add(acc.im, din.im)};
    for (int k = 2; k <= ADD_LAT; k++)
      pipe[k] <= pipe[k-1];
  end

  // accumulator: first beat overwrites, later beats take the sum
  always_ff @(posedge clk) begin
    if (reset)
      acc <= '{re: FP32_ZERO, im: FP32_ZERO};
    else if (load)
      acc <= din;
    else if (commit)
      acc <= pipe[ADD_LAT];
  end

`ifdef COMPLEX_ACC_NAN_FLAG_EN
  complex_t nxt;
  assign nxt    = load ? din : pipe[ADD_LAT];
  assign naninf = fp32_is_naninf(nxt.re) |
                  fp32_is_naninf(nxt.im);
`endif

endmodule

// File: rtl/complex_accumulator_array.sv
// Sums NUM_ACC product tiles element-wise; one adder batch in flight.
// Optional nan_flag output: define COMPLEX_ACC_NAN_FLAG_EN.
module complex_accumulator_array
  import complex_accumulator_array_pkg::*;
#(
  parameter int NUM_ACC = 16,
  parameter int ADD_LAT = 7
) (
  input logic clk,
  input logic reset,
  input logic clear,
  complex_accumulator_array_if.slave bus
);

  localparam int WW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  state_t        state, state_nxt;
  logic [15:0]   cnt;
  logic [WW-1:0] wait_cnt;
  logic          add_vld;
  logic          beat, load, launch;
  logic          add_done, commit;
  tile_t         acc;

  assign bus.in_ready  = ~reset &
                         (state == S_IDLE | state == S_ACCUM);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out       = acc;

  assign beat     = bus.in_valid & bus.in_ready & ~clear;
  assign load     = beat & (state == S_IDLE);
  assign launch   = beat & (state == S_ACCUM);
  assign add_done = (state == S_ADD) &
                    (wait_cnt == WW'(ADD_LAT - 1));
  assign commit   = add_done & add_vld & ~clear;

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // next state; clear wins over every handshake
  always_comb begin
    state_nxt = state;
    if (clear)
      state_nxt = S_IDLE;
    else begin
      unique case (state)
        S_IDLE:
          if (load)
            state_nxt = (NUM_ACC == 1) ? S_DONE : S_ACCUM;
        S_ACCUM:
          if (launch)
            state_nxt = S_ADD;
        S_ADD:
          if (add_done)
            state_nxt = (cnt == 16'(NUM_ACC)) ?
                        S_DONE : S_ACCUM;
        S_DONE:
          if (bus.out_ready)
            state_nxt = S_IDLE;
        default:
          state_nxt = S_IDLE;
      endcase
    end
  end

  // beat counter, adder wait counter and its squash bit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt      <= '0;
      wait_cnt <= '0;
      add_vld  <= 1'b0;
    end else begin
      if (load)
        cnt <= 16'd1;
      else if (launch)
        cnt <= cnt + 16'd1;
      else if (bus.out_valid && bus.out_ready)
        cnt <= '0;
      if (launch)
        wait_cnt <= '0;
      else if (state == S_ADD)
        wait_cnt <= wait_cnt + WW'(1);
      if (launch)
        add_vld <= 1'b1;
      else if (add_done)
        add_vld <= 1'b0;
    end
  end

`ifdef COMPLEX_ACC_NAN_FLAG_EN
  logic [15:0] lane_nan;
  logic        nan_q;

  // sticky per tile; restarted by the first beat
  always_ff @(posedge clk) begin
    if (reset || clear)
      nan_q <= 1'b0;
    else if (load)
      nan_q <= |lane_nan;
    else if (commit)
      nan_q <= nan_q | (|lane_nan);
  end

  assign bus.nan_flag = nan_q;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      complex_accumulator_array_lane #(
        .ADD_LAT(ADD_LAT)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .commit (commit),
        .din    (bus.in[i][j]),
        .acc    (acc[i][j])
`ifdef COMPLEX_ACC_NAN_FLAG_EN
        , .naninf (lane_nan[i*4+j])
`endif
      );
    end
  end

endmodule

// File: tb/tb_complex_accumulator_array.sv
// Bench for complex_accumulator_array: directed steps, random tiles,
// real-arithmetic reference model (values chosen to sum exactly).
module tb_complex_accumulator_array;
  import complex_accumulator_array_pkg::*;

  localparam int LAT4 = 7;
  localparam int LAT1 = 3;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic clear4 = 1'b0;
  logic clear1 = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   w;
  int   l;

  always #5 clk = ~clk;

  complex_accumulator_array_if bus4 ();
  complex_accumulator_array_if bus1 ();

  complex_accumulator_array #(
    .NUM_ACC(4),
    .ADD_LAT(LAT4)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .clear (clear4),
    .bus   (bus4.slave)
  );

  complex_accumulator_array #(
    .NUM_ACC(1),
    .ADD_LAT(LAT1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .clear (clear1),
    .bus   (bus1.slave)
  );

  real   sre [4][4];
  real   sim [4][4];
  real   mre [4][4];
  real   mim [4][4];
  tile_t stim;

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [7:0]  e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0)
      return {d[63], 31'd0};
    e = 8'(int'(d[62:52]) - 896);
    return {d[63], e, d[51:29]};
  endfunction

  function automatic real rval();
    return real'(int'($urandom_range(2000)) - 1000) / 4.0;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic set_tile(input int mode,
                          input real vre, input real vim);
    if (mode == 2)
      return;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        sre[i][j] = (mode == 0) ? rval() : vre;
        sim[i][j] = (mode == 0) ? rval() : vim;
        stim[i][j] = '{re: r2f(sre[i][j]),
                       im: r2f(sim[i][j])};
      end
  endtask

  task automatic model_beat(input logic first);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mre[i][j] = first ? sre[i][j] : mre[i][j] + sre[i][j];
        mim[i][j] = first ? sim[i][j] : mim[i][j] + sim[i][j];
      end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 4) begin
      bus4.in       = stim;
      bus4.in_valid = v;
    end else begin
      bus1.in       = stim;
      bus1.in_valid = v;
    end
  endtask

  task automatic set_ordy(input int which, input logic v);
    if (which == 4)
      bus4.out_ready = v;
    else
      bus1.out_ready = v;
  endtask

  function automatic logic rdy(input int which);
    return (which == 4) ? bus4.in_ready : bus1.in_ready;
  endfunction

  function automatic logic ovld(input int which);
    return (which == 4) ? bus4.out_valid : bus1.out_valid;
  endfunction

  function automatic tile_t outt(input int which);
    return (which == 4) ? bus4.out : bus1.out;
  endfunction

  task automatic chk_tile(input string tag, input int which);
    tile_t o;
    o = outt(which);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j), o[i][j],
            {r2f(mre[i][j]), r2f(mim[i][j])});
  endtask

  // waits (bounded) for in_ready, then presents one beat
  task automatic beat(input int which, output int waited);
    waited = 0;
    while (!rdy(which) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    drive(which, 1'b1);
    @(negedge clk);
    drive(which, 1'b0);
  endtask

  task automatic run_tile(input int which, input int nacc,
                          input int lat, input int mode,
                          input real vre, input real vim,
                          input string tag);
    int wt, lt;
    for (int b = 0; b < nacc; b++) begin
      set_tile(mode, vre, vim);
      beat(which, wt);
      model_beat(b == 0);
      chk({tag, "_wait"}, 64'(wt), 64'((b >= 2) ? lat : 0));
    end
    lt = 0;
    while (!ovld(which) && lt < 200) begin
      @(negedge clk);
      lt++;
    end
    chk({tag, "_lat"}, 64'(lt), 64'((nacc == 1) ? 0 : lat));
    chk_tile(tag, which);
  endtask

  task automatic release_out(input int which, input string tag);
    set_ordy(which, 1'b1);
    @(negedge clk);
    set_ordy(which, 1'b0);
    chk({tag, "_rel_ovld"}, 64'(ovld(which)), 64'd0);
    chk({tag, "_rel_irdy"}, 64'(rdy(which)), 64'd1);
  endtask

  initial begin
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.in        = '0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.in        = '0;
    stim           = '0;

    repeat (3) @(negedge clk);
    chk("rst_irdy", 64'(bus4.in_ready), 64'd0);
    chk("rst_ovld", 64'(bus4.out_valid), 64'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("rst_out", bus4.out[i][j], 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_irdy4", 64'(bus4.in_ready), 64'd1);
    chk("post_rst_irdy1", 64'(bus1.in_ready), 64'd1);

    run_tile(4, 4, LAT4, 1, 1.0, 1.0, "ones");
    chk("ones_const", bus4.out[1][2],
        {32'h4080_0000, 32'h4080_0000});
    release_out(4, "ones");

    for (int t = 0; t < 3; t++) begin
      run_tile(4, 4, LAT4, 0, 0.0, 0.0, "rand4");
      release_out(4, "rand4");
    end

    run_tile(4, 4, LAT4, 0, 0.0, 0.0, "bp");
    for (int k = 0; k < 10; k++) begin
      set_tile(0, 0.0, 0.0);
      drive(4, 1'b1);
      @(negedge clk);
      chk("bp_ovld", 64'(bus4.out_valid), 64'd1);
      chk("bp_irdy", 64'(bus4.in_ready), 64'd0);
      chk_tile("bp_hold", 4);
    end
    drive(4, 1'b0);
    release_out(4, "bp");
    run_tile(4, 4, LAT4, 0, 0.0, 0.0, "bp_next");
    release_out(4, "bp_next");

    set_tile(0, 0.0, 0.0);
    drive(4, 1'b1);
    clear4 = 1'b1;
    @(negedge clk);
    clear4 = 1'b0;
    drive(4, 1'b0);
    run_tile(4, 4, LAT4, 0, 0.0, 0.0, "clr_idle");
    release_out(4, "clr_idle");

    set_tile(0, 0.0, 0.0);
    beat(4, w);
    set_tile(0, 0.0, 0.0);
    beat(4, w);
    @(negedge clk);
    @(negedge clk);
    clear4 = 1'b1;
    @(negedge clk);
    clear4 = 1'b0;
    chk("clr_add_ovld", 64'(bus4.out_valid), 64'd0);
    chk("clr_add_irdy", 64'(bus4.in_ready), 64'd1);
    run_tile(4, 4, LAT4, 1, 2.0, 2.0, "clr_fresh");
    chk("clr_fresh_const", bus4.out[3][0],
        {32'h4100_0000, 32'h4100_0000});
    release_out(4, "clr_fresh");

    set_tile(1, 0.0, 0.0);
    sre[2][3]  = 3.0;
    sim[2][3]  = -2.0;
    stim[2][3] = '{re: r2f(3.0), im: r2f(-2.0)};
    run_tile(1, 1, LAT1, 2, 0.0, 0.0, "one");
    chk("one_const", bus1.out[2][3],
        {32'h4040_0000, 32'hC000_0000});
    release_out(1, "one");
    for (int t = 0; t < 2; t++) begin
      run_tile(1, 1, LAT1, 0, 0.0, 0.0, "rand1");
      release_out(1, "rand1");
    end

`ifdef COMPLEX_ACC_NAN_FLAG_EN
    for (int b = 0; b < 4; b++) begin
      set_tile(0, 0.0, 0.0);
      if (b == 1)
        stim[1][2].re = 32'h7F80_0000;
      beat(4, w);
    end
    l = 0;
    while (!bus4.out_valid && l < 200) begin
      @(negedge clk);
      l++;
    end
    chk("nan_lat", 64'(l), 64'(LAT4));
    chk("nan_set", 64'(bus4.nan_flag), 64'd1);
    release_out(4, "nan");
    run_tile(4, 4, LAT4, 0, 0.0, 0.0, "nan_next");
    chk("nan_clr", 64'(bus4.nan_flag), 64'd0);
    release_out(4, "nan_next");
`endif

    run_tile(4, 4, LAT4, 0, 0.0, 0.0, "rst_done");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_done_ovld", 64'(bus4.out_valid), 64'd0);
    chk("rst_done_irdy", 64'(bus4.in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done_irdy1", 64'(bus4.in_ready), 64'd1);
    run_tile(4, 4, LAT4, 0, 0.0, 0.0, "after_rst");
    release_out(4, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
